merge_event_aligner_n: RTL and testbench

- N-channel successor to the single-stream merge event handler.
- Takes N_CH cluster event streams from first-word-fall-through FIFOs (one per detector slice) and aligns them on event boundaries.
- Emits one merged event to the board-to-board output FIFO: one event header, then module blocks interleaved round-robin at module boundaries, then one event footer.

---
 rtl/meh_pkg.sv | 50 +++++
 rtl/meh_rr_arbiter.sv | 46 ++++
 rtl/merge_event_aligner_n.sv | 261 ++++++++++++++++++++++++++
 tb/tb_merge_event_aligner_n.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meh_pkg.sv
// Shared definitions for merge_event_aligner_n: word layout, flag codes,
// FSM state encoding and the word classifier.
package meh_pkg;

    // Word layout for the 65-bit link word.
    localparam int MEH_DW       = 65;
    localparam int META_BIT     = MEH_DW - 1;   // 1 = metadata word
    localparam int MOD_LAST_BIT = MEH_DW - 2;   // data word: last word of module
    localparam int FLAG_MSB     = 63;           // metadata flag field
    localparam int FLAG_LSB     = 60;
    localparam int L0ID_LSB     = 0;            // L0ID field in the EVT_HDR word

    localparam logic [3:0] FLAG_EVT_HDR = 4'hB;
    localparam logic [3:0] FLAG_M_HDR   = 4'h5;
    localparam logic [3:0] FLAG_EVT_FTR = 4'hE;

    typedef enum logic [2:0] {
        ST_HDR_WAIT,
        ST_HDR_TX,
        ST_MOD_SEL,
        ST_MOD_TX,
        ST_FTR_TX
    } state_t;

    typedef enum logic [2:0] {
        WT_DATA,
        WT_LAST,
        WT_EVT_HDR,
        WT_M_HDR,
        WT_EVT_FTR,
        WT_META
    } word_t;

    // tag = {meta, flag[3:0]}; flag[3] doubles as the module-last bit of data words
    function automatic word_t decode_word(input logic [META_BIT-FLAG_LSB:0] tag);
        word_t wt;
        if (!tag[META_BIT-FLAG_LSB]) begin
            wt = tag[MOD_LAST_BIT-FLAG_LSB] ? WT_LAST : WT_DATA;
        end else begin
            case (tag[FLAG_MSB-FLAG_LSB:0])
                FLAG_EVT_HDR: wt = WT_EVT_HDR;
                FLAG_M_HDR:   wt = WT_M_HDR;
                FLAG_EVT_FTR: wt = WT_EVT_FTR;
                default:      wt = WT_META;
            endcase
        end
        return wt;
    endfunction

endpackage

// File: rtl/meh_rr_arbiter.sv
// Round-robin grant among requesting channels, starting the search at a
// pointer that moves past the last served channel on the advance strobe.
module meh_rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst_n,
    input  logic [N_CH-1:0]   req,
    input  logic              advance,
    input  logic [IDX_W-1:0]  adv_idx,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr_q;

    // first requester at or after the pointer, wrapping around
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < N_CH; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_CH) j = j - N_CH;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    // pointer moves to served channel + 1 mod N_CH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (!srst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (adv_idx == IDX_W'(N_CH - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/merge_event_aligner_n.sv
// Merges N_CH FWFT event streams into one event: master header, module
// blocks round-robin, master footer. Optional L0ID cross-check is built
// when MEH_L0ID_CHECK_EN is defined; otherwise err_l0id is tied low.
//
// state      | meaning
// HDR_WAIT   | idle; wait for EVT_HDR on every enabled head, drop junk
// HDR_TX     | forward master header, drop the other headers
// MOD_SEL    | mark footer heads done, pick next M_HDR round-robin
// MOD_TX     | forward one module from the granted channel
// FTR_TX     | forward master footer, drop the others, count event
module merge_event_aligner_n
    import meh_pkg::*;
#(
    parameter int DATA_WIDTH    = 65,
    parameter int N_CH          = 4,
    parameter int EVT_HDR_WORDS = 6,
    parameter int EVT_FTR_WORDS = 3,
    parameter int L0ID_BITS     = 40,
    parameter int MEH_ID        = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       srst_n,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]            in_empty,
    output logic [N_CH-1:0]            in_rd,
    input  logic [N_CH-1:0]            ch_enable,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_wren,
    input  logic                       out_almost_full,
    output logic [L0ID_BITS-1:0]       evt_l0id,
    output logic                       busy,
    output logic [15:0]                evt_count,
    output logic                       err_proto,
    output logic                       err_l0id
);

    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_MAX = (EVT_HDR_WORDS > EVT_FTR_WORDS) ? EVT_HDR_WORDS : EVT_FTR_WORDS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                state_q, state_d;
    logic [N_CH-1:0]       en_q, done_q, en_cur;
    logic [IDX_W-1:0]      master_q, master_cur, gnt_q, fwd_idx, arb_idx;
    logic                  mod_first_q, arb_valid, arb_adv;
    logic [CNT_W-1:0]      cnt_q [N_CH];
    logic [DATA_WIDTH-1:0] head [N_CH];
    word_t                 wt [N_CH];
    logic [N_CH-1:0]       is_hdr, is_mhdr, is_ftr, cnt_zero;
    logic [N_CH-1:0]       ftr_mask, req_mask, bad_sel, rd_c;
    logic                  hdr_ok, cnt_done, all_done, fwd, proto_set;
    logic                  g_empty, mod_meta_end, mod_fwd, mod_end;
    word_t                 g_wt;

    assign en_cur = (state_q == ST_HDR_WAIT) ? ch_enable : en_q;
    assign busy   = (state_q != ST_HDR_WAIT);
    // no reads while either reset is asserted, so nothing is consumed unseen
    assign in_rd  = rd_c & {N_CH{rst_n & srst_n}};

    // head decode and per-channel condition vectors
    always_comb begin
        is_hdr   = '0;
        is_mhdr  = '0;
        is_ftr   = '0;
        cnt_zero = '0;
        for (int i = 0; i < N_CH; i++) begin
            head[i]     = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            wt[i]       = decode_word(head[i][META_BIT:FLAG_LSB]);
            is_hdr[i]   = (wt[i] == WT_EVT_HDR);
            is_mhdr[i]  = (wt[i] == WT_M_HDR);
            is_ftr[i]   = (wt[i] == WT_EVT_FTR);
            cnt_zero[i] = (cnt_q[i] == '0);
        end
        master_cur = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_cur[i]) master_cur = IDX_W'(i);
        end
        hdr_ok   = (en_cur != '0) && ((~en_cur | (~in_empty & is_hdr)) == {N_CH{1'b1}});
        cnt_done = ((~en_q | cnt_zero) == {N_CH{1'b1}});
        ftr_mask = en_q & ~done_q & ~in_empty & is_ftr;
        req_mask = en_q & ~done_q & ~in_empty & is_mhdr;
        bad_sel  = en_q & ~done_q & ~in_empty & ~is_ftr & ~is_mhdr;
        all_done = (((done_q | ftr_mask) & en_q) == en_q);
        g_empty      = in_empty[gnt_q];
        g_wt         = wt[gnt_q];
        mod_meta_end = !mod_first_q && !g_empty && (g_wt != WT_DATA) && (g_wt != WT_LAST);
        mod_fwd      = !g_empty && !out_almost_full && !mod_meta_end;
        mod_end      = mod_meta_end || (mod_fwd && (g_wt == WT_LAST));
    end

    assign arb_adv = (state_q == ST_MOD_TX) && mod_end;

    meh_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .srst_n      (srst_n),
        .req         (req_mask),
        .advance     (arb_adv),
        .adv_idx     (gnt_q),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR_WAIT;
        end else if (!srst_n) begin
            state_q <= ST_HDR_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR_WAIT: if (hdr_ok) state_d = ST_HDR_TX;
            ST_HDR_TX:   if (cnt_done) state_d = ST_MOD_SEL;
            ST_MOD_SEL: begin
                if (arb_valid)     state_d = ST_MOD_TX;
                else if (all_done) state_d = ST_FTR_TX;
            end
            ST_MOD_TX:   if (mod_end) state_d = ST_MOD_SEL;
            ST_FTR_TX:   if (cnt_done) state_d = ST_HDR_WAIT;
            default:     state_d = ST_HDR_WAIT;
        endcase
    end

    // read strobes, forward select and protocol-error strobe per state
    always_comb begin
        rd_c      = '0;
        fwd       = 1'b0;
        fwd_idx   = master_q;
        proto_set = 1'b0;
        case (state_q)
            ST_HDR_WAIT: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (en_cur[i] && !in_empty[i] && !is_hdr[i]) begin
                        proto_set = 1'b1;
                        rd_c[i]   = !out_almost_full;
                    end
                end
            end
            ST_HDR_TX, ST_FTR_TX: begin
                for (int i = 0; i < N_CH; i++) begin
                    rd_c[i] = en_q[i] && !cnt_zero[i] && !in_empty[i] && !out_almost_full;
                end
                fwd = rd_c[master_q];
            end
            ST_MOD_SEL: begin
                rd_c      = bad_sel & {N_CH{!out_almost_full}};
                proto_set = (bad_sel != '0);
            end
            ST_MOD_TX: begin
                rd_c[gnt_q] = mod_fwd;
                fwd         = mod_fwd;
                fwd_idx     = gnt_q;
                proto_set   = mod_meta_end;
            end
            default: ;
        endcase
    end

    // event bookkeeping, word counters and registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            master_q    <= '0;
            done_q      <= '0;
            gnt_q       <= '0;
            mod_first_q <= 1'b0;
            evt_l0id    <= '0;
            out_data    <= '0;
            out_wren    <= 1'b0;
            evt_count   <= '0;
            err_proto   <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (!srst_n) begin
            en_q        <= '0;
            master_q    <= '0;
            done_q      <= '0;
            gnt_q       <= '0;
            mod_first_q <= 1'b0;
            evt_l0id    <= '0;
            out_data    <= '0;
            out_wren    <= 1'b0;
            evt_count   <= '0;
            err_proto   <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            out_wren <= fwd;
            if (fwd) out_data <= head[fwd_idx];
            if (proto_set) err_proto <= 1'b1;
            if (state_q == ST_HDR_WAIT) begin
                en_q     <= ch_enable;
                master_q <= master_cur;
            end
            if (state_q == ST_HDR_WAIT && state_d == ST_HDR_TX) begin
                evt_l0id <= head[master_cur][L0ID_LSB +: L0ID_BITS];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (state_q == ST_HDR_WAIT && state_d == ST_HDR_TX) begin
                    cnt_q[i] <= CNT_W'(EVT_HDR_WORDS);
                end else if (state_q == ST_MOD_SEL && state_d == ST_FTR_TX) begin
                    cnt_q[i] <= CNT_W'(EVT_FTR_WORDS);
                end else if (rd_c[i] && (state_q == ST_HDR_TX || state_q == ST_FTR_TX)) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (state_q == ST_MOD_SEL) begin
                done_q <= done_q | ftr_mask;
                if (arb_valid) begin
                    gnt_q       <= arb_idx;
                    mod_first_q <= 1'b1;
                end
            end
            if (state_q == ST_MOD_TX && mod_fwd) mod_first_q <= 1'b0;
            if (state_q == ST_FTR_TX && cnt_done) begin
                evt_count <= evt_count + 16'd1;
                done_q    <= '0;
                evt_l0id  <= '0;
            end
        end
    end

`ifdef MEH_L0ID_CHECK_EN
    logic [N_CH-1:0] l0id_neq;
    logic [31:0]     unused_meh_id;
    assign unused_meh_id = MEH_ID;

    // header L0IDs of enabled channels against the master's
    always_comb begin
        l0id_neq = '0;
        for (int i = 0; i < N_CH; i++) begin
            l0id_neq[i] = en_cur[i] &&
                (head[i][L0ID_LSB +: L0ID_BITS] != head[master_cur][L0ID_LSB +: L0ID_BITS]);
        end
    end

    // sticky mismatch flag, evaluated when the event is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_l0id <= 1'b0;
        end else if (!srst_n) begin
            err_l0id <= 1'b0;
        end else if (state_q == ST_HDR_WAIT && state_d == ST_HDR_TX && l0id_neq != '0) begin
            err_l0id <= 1'b1;
        end
    end
`else
    logic [31:0] unused_meh_id;
    assign unused_meh_id = MEH_ID;
    assign err_l0id      = 1'b0;
`endif

endmodule

// File: tb/tb_merge_event_aligner_n.sv
// Directed bench for merge_event_aligner_n: FIFO models per channel, the
// expected merged stream built from the same event recipe, checks by
// immediate assertion.
module tb_merge_event_aligner_n;

    localparam int DW = 65;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n, srst_n;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_empty, in_rd, ch_enable;
    logic [DW-1:0]   out_data;
    logic            out_wren, out_almost_full;
    logic [39:0]     evt_l0id;
    logic            busy;
    logic [15:0]     evt_count;
    logic            err_proto, err_l0id;

    logic [DW-1:0] fifo [N][$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    logic [N-1:0]  hide;
    int            tests = 0;
    int            fails = 0;
    int            rd_viol = 0;
    int            rd_cnt [N];
    int            exp_err_l0id;

    always #5 clk = ~clk;

    merge_event_aligner_n dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .srst_n          (srst_n),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_rd           (in_rd),
        .ch_enable       (ch_enable),
        .out_data        (out_data),
        .out_wren        (out_wren),
        .out_almost_full (out_almost_full),
        .evt_l0id        (evt_l0id),
        .busy            (busy),
        .evt_count       (evt_count),
        .err_proto       (err_proto),
        .err_l0id        (err_l0id)
    );

    function automatic logic [DW-1:0] w_ehdr(int ch, logic [39:0] l0id);
        return {1'b1, 4'hB, 20'(ch), l0id};
    endfunction
    function automatic logic [DW-1:0] w_mhdr(int ch, int m);
        return {1'b1, 4'h5, 44'd0, 8'(ch), 8'(m)};
    endfunction
    function automatic logic [DW-1:0] w_eftr(int ch);
        return {1'b1, 4'hE, 60'(ch)};
    endfunction
    function automatic logic [DW-1:0] w_data(int ch, int seq, logic last);
        return {1'b0, last, 47'd0, 8'(ch), 8'(seq)};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            in_empty[i]          = (fifo[i].size() == 0) || hide[i];
            in_data[i*DW +: DW]  = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
    endtask

    // one clock: sample strobes at negedge, apply pops/capture after posedge
    task automatic tick();
        logic [N-1:0] rd_s;
        @(negedge clk);
        rd_s = in_rd;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i]) begin
                rd_cnt[i]++;
                if (in_empty[i] || out_almost_full) rd_viol++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        if (out_wren) got_q.push_back(out_data);
        refresh();
    endtask

    task automatic load_event(int ch, logic [39:0] l0id, int nmod);
        fifo[ch].push_back(w_ehdr(ch, l0id));
        for (int k = 1; k < 6; k++) fifo[ch].push_back(w_data(ch, k, 1'b0));
        for (int m = 0; m < nmod; m++) begin
            fifo[ch].push_back(w_mhdr(ch, m));
            fifo[ch].push_back(w_data(ch, 16 + 2*m, 1'b0));
            fifo[ch].push_back(w_data(ch, 17 + 2*m, 1'b1));
        end
        fifo[ch].push_back(w_eftr(ch));
        fifo[ch].push_back(w_data(ch, 100, 1'b0));
        fifo[ch].push_back(w_data(ch, 101, 1'b0));
    endtask

    task automatic exp_hdr(int ch, logic [39:0] l0id);
        exp_q.push_back(w_ehdr(ch, l0id));
        for (int k = 1; k < 6; k++) exp_q.push_back(w_data(ch, k, 1'b0));
    endtask
    task automatic exp_mod(int ch, int m);
        exp_q.push_back(w_mhdr(ch, m));
        exp_q.push_back(w_data(ch, 16 + 2*m, 1'b0));
        exp_q.push_back(w_data(ch, 17 + 2*m, 1'b1));
    endtask
    task automatic exp_ftr(int ch);
        exp_q.push_back(w_eftr(ch));
        exp_q.push_back(w_data(ch, 100, 1'b0));
        exp_q.push_back(w_data(ch, 101, 1'b0));
    endtask

    task automatic new_test();
        for (int i = 0; i < N; i++) begin
            fifo[i].delete();
            rd_cnt[i] = 0;
        end
        exp_q.delete();
        got_q.delete();
        hide = '0;
        refresh();
    endtask

    task automatic run_until(int n, int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic finish_event(string tag);
        int nbad = 0;
        int n;
        n = exp_q.size();
        run_until(n, 500);
        repeat (4) tick();
        check({tag, "_wcount"}, got_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                if (nbad == 0 && k < got_q.size())
                    $display("[TB] %s first diff at word %0d: %0h vs %0h", tag, k, got_q[k], exp_q[k]);
                nbad++;
            end
        end
        check({tag, "_seq_bad_words"}, nbad, 0);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_l0id_end"}, evt_l0id, 0);
    endtask

    initial begin
        int snap_w, snap_r;
`ifdef MEH_L0ID_CHECK_EN
        exp_err_l0id = 1;
`else
        exp_err_l0id = 0;
`endif
        rst_n = 1'b0;
        srst_n = 1'b1;
        ch_enable = '0;
        out_almost_full = 1'b0;
        hide = '0;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        refresh();
        repeat (3) tick();
        check("rst_out_wren", out_wren, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_rd", in_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_evt_count", evt_count, 0);
        check("rst_err_proto", err_proto, 0);
        rst_n = 1'b1;
        tick();

        // 1: all channels, 2 modules each, pointer starts at 0
        new_test();
        ch_enable = 4'hF;
        for (int c = 0; c < N; c++) load_event(c, 40'h12, 2);
        refresh();
        exp_hdr(0, 40'h12);
        for (int m = 0; m < 2; m++) for (int c = 0; c < N; c++) exp_mod(c, m);
        exp_ftr(0);
        run_until(1, 50);
        check("t1_l0id", evt_l0id, 40'h12);
        check("t1_busy", busy, 1);
        finish_event("t1");
        check("t1_evt_count", evt_count, 1);
        check("t1_err_proto", err_proto, 0);

        // 2: mask 0110 -> master ch1, ch0/ch3 untouched; pointer 0 -> 1,2,1,2
        new_test();
        for (int c = 0; c < N; c++) load_event(c, 40'h12, 2);
        ch_enable = 4'b0110;
        refresh();
        exp_hdr(1, 40'h12);
        exp_mod(1, 0); exp_mod(2, 0); exp_mod(1, 1); exp_mod(2, 1);
        exp_ftr(1);
        finish_event("t2");
        check("t2_ch0_reads", rd_cnt[0], 0);
        check("t2_ch3_reads", rd_cnt[3], 0);
        check("t2_ch0_left", fifo[0].size(), 15);
        check("t2_evt_count", evt_count, 2);

        // 3: almost-full mid-module; pointer 3 -> order 3,0,1,2
        new_test();
        ch_enable = 4'hF;
        for (int c = 0; c < N; c++) load_event(c, 40'h12, 2);
        refresh();
        exp_hdr(0, 40'h12);
        for (int m = 0; m < 2; m++) for (int k = 0; k < N; k++) exp_mod((3 + k) % N, m);
        exp_ftr(0);
        run_until(10, 200);
        out_almost_full = 1'b1;
        refresh();
        snap_w = got_q.size();
        snap_r = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
        repeat (10) tick();
        check("t3_af_reads", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - snap_r, 0);
        check("t3_af_writes", got_q.size() - snap_w, 0);
        out_almost_full = 1'b0;
        finish_event("t3");
        check("t3_evt_count", evt_count, 3);

        // 4: ch2 runs empty right after its M_HDR for 5 cycles
        new_test();
        for (int c = 0; c < N; c++) load_event(c, 40'h12, 2);
        refresh();
        exp_hdr(0, 40'h12);
        for (int m = 0; m < 2; m++) for (int k = 0; k < N; k++) exp_mod((3 + k) % N, m);
        exp_ftr(0);
        run_until(16, 200);
        check("t4_word15", got_q[15], w_mhdr(2, 0));
        hide[2] = 1'b1;
        refresh();
        snap_w = got_q.size();
        snap_r = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
        repeat (5) tick();
        check("t4_stall_reads", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - snap_r, 0);
        check("t4_stall_writes", got_q.size() - snap_w, 0);
        check("t4_stall_busy", busy, 1);
        hide[2] = 1'b0;
        refresh();
        finish_event("t4");
        check("t4_evt_count", evt_count, 4);

        // 5: ch3 carries L0ID 0x13; master ch0 still 0x12
        new_test();
        for (int c = 0; c < 3; c++) load_event(c, 40'h12, 1);
        load_event(3, 40'h13, 1);
        refresh();
        exp_hdr(0, 40'h12);
        exp_mod(3, 0); exp_mod(0, 0); exp_mod(1, 0); exp_mod(2, 0);
        exp_ftr(0);
        run_until(1, 50);
        check("t5_l0id", evt_l0id, 40'h12);
        check("t5_err_l0id", err_l0id, exp_err_l0id);
        finish_event("t5");
        check("t5_evt_count", evt_count, 5);
        check("t5_err_l0id_sticky", err_l0id, exp_err_l0id);

        // 6: asynchronous reset in the middle of a module
        new_test();
        for (int c = 0; c < N; c++) load_event(c, 40'h12, 2);
        refresh();
        run_until(8, 200);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_count", evt_count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wren", out_wren, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_in_rd", in_rd, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", evt_count, 0);
        check("t6_rst_l0id", evt_l0id, 0);
        check("t6_rst_err_l0id", err_l0id, 0);
        new_test();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_post_busy", busy, 0);
        check("t6_post_count", evt_count, 0);
        check("t6_post_wren", out_wren, 0);

        // 7: junk data word ahead of the header is dropped and flagged
        new_test();
        ch_enable = 4'b0001;
        fifo[0].push_back(w_data(0, 200, 1'b0));
        load_event(0, 40'h21, 1);
        refresh();
        exp_hdr(0, 40'h21);
        exp_mod(0, 0);
        exp_ftr(0);
        finish_event("t7");
        check("t7_err_proto", err_proto, 1);
        check("t7_err_l0id", err_l0id, 0);
        check("t7_evt_count", evt_count, 1);

        // 8: soft reset clears counters and sticky flags
        srst_n = 1'b0;
        tick();
        check("t8_srst_count", evt_count, 0);
        check("t8_srst_err", err_proto, 0);
        srst_n = 1'b1;
        tick();

        check("read_rule_violations", rd_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
